// File: rtl/dm_arbiter.sv
// Two-master round-robin arbiter and read-modify-write sequencer in front of the data memory.
// Define DM_ARB_ERR_EN to add m0_err/m1_err, which flag misaligned requests whose lanes leave the word.
module dm_arbiter #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [3:0]    m0_be,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [3:0]    m1_be,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
`ifdef DM_ARB_ERR_EN
  output logic          m0_err,
  output logic          m1_err,
`endif
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic          dm_we,
  input  logic [DW-1:0] dm_dout
);

  typedef enum logic [1:0] {StIdle, StAccess, StWrite, StDone} state_e;

  state_e        state_q, state_d;
  logic          last_grant_q;
  logic          gnt_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    be_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rbuf_q;
  logic          err_q;

  logic          req_any;
  logic          win;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [3:0]    sel_be;
  logic [DW-1:0] sel_wdata;
  logic          sel_err;
  logic [3:0]    low_mask;
  logic          wr_go;
  logic [AW-1:0] word_addr;
  logic [DW-1:0] merged;

  // On a tie the master that did not win last time gets the grant.
  assign req_any   = m0_req | m1_req;
  assign win       = (m0_req & m1_req) ? ~last_grant_q : m1_req;
  assign sel_we    = win ? m1_we    : m0_we;
  assign sel_addr  = win ? m1_addr  : m0_addr;
  assign sel_be    = win ? m1_be    : m0_be;
  assign sel_wdata = win ? m1_wdata : m0_wdata;
  assign low_mask  = (4'd1 << sel_addr[1:0]) - 4'd1;

`ifdef DM_ARB_ERR_EN
  assign sel_err = |(sel_be & low_mask);
`else
  assign sel_err = 1'b0;
`endif

  assign wr_go     = we_q && (be_q != 4'b0000) && !err_q;
  assign word_addr = {addr_q[AW-1:2], 2'b00};

  always_comb begin
    merged = rbuf_q;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_any) state_d = StAccess;
      StAccess: state_d = wr_go ? StWrite : StDone;
      StWrite:  state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      if (state_q == StIdle && req_any) begin
        last_grant_q <= win;
        gnt_q        <= win;
        we_q         <= sel_we;
        addr_q       <= sel_addr;
        be_q         <= sel_be;
        wdata_q      <= sel_wdata;
        err_q        <= sel_err;
      end
      if (state_q == StAccess) rbuf_q <= dm_dout;
    end
  end

  always_comb begin
    dm_addr  = '0;
    dm_din   = '0;
    dm_we    = 1'b0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
`ifdef DM_ARB_ERR_EN
    m0_err   = 1'b0;
    m1_err   = 1'b0;
`endif
    unique case (state_q)
      StAccess: dm_addr = word_addr;
      StWrite: begin
        dm_addr = word_addr;
        dm_din  = merged;
        dm_we   = !rst;
      end
      StDone: begin
        if (gnt_q) begin
          m1_ack   = 1'b1;
          m1_rdata = err_q ? '0 : rbuf_q;
`ifdef DM_ARB_ERR_EN
          m1_err   = err_q;
`endif
        end else begin
          m0_ack   = 1'b1;
          m0_rdata = err_q ? '0 : rbuf_q;
`ifdef DM_ARB_ERR_EN
          m0_err   = err_q;
`endif
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-master arbiter and access sequencer in front of the 1 KB byte-addressed data memory (10-bit address, 32-bit word, synchronous write, combinational read).
- Master 0 is the CPU data port; master 1 is the debug/loader port.
- Shares the memory between the two masters using round-robin arbitration.
- Implements byte-enable stores as a read-modify-write so that sb/sh work on a word-write memory.

Parameters:
- AW, 10, byte-address width of the memory.
- DW, 32, data width. Fixed at 32; the byte enables are 4 bits.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 request; held until m0_ack.
- m0_we  in  1  master 0 write (1) or read (0).
- m0_addr  in  AW  master 0 byte address.
- m0_be  in  4  master 0 byte enables; bit i covers byte lane i, bits [8i+7:8i].
- m0_wdata  in  32  master 0 write data, lane-aligned.
- m0_ack  out  1  one-cycle completion pulse to master 0.
- m0_rdata  out  32  read data, valid while m0_ack is high.
- m1_req, m1_we, m1_addr, m1_be, m1_wdata, m1_ack, m1_rdata  same as master 0, for master 1.
- dm_addr  out  AW  memory address, always word-aligned: {addr[AW-1:2],2'b00}.
- dm_din  out  32  memory write data.
- dm_we  out  1  memory write enable.
- dm_dout  in  32  memory read data (combinational from dm_addr).

Behaviour:
- States:
  - IDLE: sample requests; if either is high, latch the winner's we/addr/be/wdata and go to ACCESS.
  - ACCESS: drive dm_addr and capture dm_dout into rbuf. Go to WRITE if (we && be!=0), else to DONE.
  - WRITE: dm_we=1; dm_din = per-lane merge (be[i] ? wdata lane : rbuf lane). Go to DONE.
  - DONE: ack for the granted master = 1; its rdata = rbuf. Go to IDLE.
- Latency, with the request sampled in IDLE at cycle N:
  - read: ack in cycle N+2.
  - write: dm_we high in N+2, ack in N+3.
  - A master may assert req again from the cycle after its ack; the next arbitration happens no earlier than that cycle.
- Requesters hold req and payload stable until ack. The arbiter latches the payload in IDLE, so changes after that cycle are ignored.
- The request of the non-granted master is not sampled outside IDLE; it stays pending.
- Arbitration: round-robin on a 1-bit last_grant.
  - If only one master requests, it wins.
  - If both request, the master != last_grant wins.
  - last_grant is updated on every grant.
- dm_we is high only in WRITE and is forced to 0 whenever rst=1.
- At most one ack per cycle. m0_ack and m1_ack are never high together.
- rdata outputs return 0 when not acking.
- dm_addr/dm_din are 0 in IDLE.
- we=1 with be=4'b0000: no memory write; completes as a read (ack at N+2, rdata = current word).
- addr[1:0] is ignored for the access; the word at addr & ~3 is used.
- Top word (addr=1020..1023) is legal; the address is never incremented, so no wrap is possible.
- Reset:
  - state=IDLE, last_grant=1 (master 0 wins the first tie), rbuf=0, all acks 0, dm_we=0, from the edge where rst=1 is sampled.
  - Reset mid-operation abandons the transaction with no ack and no write.
  - A write already committed in an earlier WRITE cycle stays in memory.

Optional Feature:
- Macro: DM_ARB_ERR_EN.
- When defined:
  - Adds outputs m0_err and m1_err (1 bit each), asserted together with the corresponding ack.
  - err is raised when addr[1:0] != 0 and be spans beyond the word: any enabled lane i with i < addr[1:0].
  - A request with err=1 skips WRITE: no memory write, rdata = 0.
  - err is 0 at reset.
- When not defined: the err ports do not exist and misaligned requests behave as stated above.

Test Plan:
- Reset, then m0 writes addr=0x010, be=4'b1111, wdata=0xDEADBEEF -> dm_we in cycle N+2 with dm_addr=0x010, dm_din=0xDEADBEEF; m0_ack at N+3; then m0 reads 0x010 -> m0_rdata=0xDEADBEEF at N+2.
- Word 0x020=0x11223344; m1 writes be=4'b0010, wdata=0x0000AA00 -> memory word becomes 0x1122AA44; m1 reads 0x020 -> 0x1122AA44.
- m0 and m1 request reads in the same cycle right after reset -> m0 acked first, m1 acked 3 cycles later; both keep requesting -> grants alternate m0, m1, m0, m1.
- m0 write with be=4'b0000 to 0x3FC holding 0x55667788 -> no dm_we pulse; ack at N+2 with rdata=0x55667788.
- rst asserted in the WRITE cycle of an m1 write to 0x040 -> dm_we=0 in that cycle, no m1_ack, memory unchanged; the first request after reset is granted to m0 on a tie.
- With DM_ARB_ERR_EN: m0 write addr=0x012, be=4'b0011 -> m0_err=1 with m0_ack, memory unchanged; addr=0x012, be=4'b1100 -> err=0 and the write occurs.
